// File: rtl/timing_ctrl_team1.sv
// -----------------------------------------------------------------------------
// timing_ctrl_team1
//
// Instruction-cycle sequencer for the team1 basic computer. Holds the sequence
// counter (SC), the start/stop flip-flop (S), the instruction register (IR) and
// the registered fetch decode (I, D, B), and produces the one-hot timing
// signals T consumed by the accumulator control decode.
//
// Ports
//   clk     in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   START   in   level; sets S while the machine is halted
//   bus_in  in   memory word, captured into IR at the edge ending T1
//   SC_CLR  in   end-of-instruction from memory-reference control (SC >= 3)
//   T       out  one-hot timing signals, all zero while halted
//   D       out  registered one-hot decode of IR[14:12]
//   I       out  registered IR[15] (indirect bit)
//   B       out  registered IR[11:0]
//   IR_out  out  instruction register contents
//   S       out  1 = running, 0 = halted
//
// Configuration
//   TIMING_CTRL_HLT_EN  defined: HLT (D[7], I=0, B[0]=1 at T3) clears S.
//                       undefined: HLT behaves as a register-reference NOP and
//                       only reset clears S.
// -----------------------------------------------------------------------------
module timing_ctrl_team1 #(
  parameter int SC_WIDTH = 4,
  parameter int WORD     = 16
) (
  input  logic                     clk,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [WORD-1:0]          bus_in,
  input  logic                     SC_CLR,
  output logic [(2**SC_WIDTH)-1:0] T,
  output logic [7:0]               D,
  output logic                     I,
  output logic [WORD-5:0]          B,
  output logic [WORD-1:0]          IR_out,
  output logic                     S
);

  localparam int TW = 2**SC_WIDTH;
  localparam int BW = WORD - 4;

  localparam logic [SC_WIDTH-1:0] SC_ONE = SC_WIDTH'(1);
  localparam logic [SC_WIDTH-1:0] SC_T2  = SC_WIDTH'(2);
  localparam logic [SC_WIDTH-1:0] SC_T3  = SC_WIDTH'(3);

  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic                s_q, s_d;
  logic [WORD-1:0]     ir_q, ir_d;
  logic [7:0]          d_q, d_d;
  logic                i_q, i_d;
  logic [BW-1:0]       b_q, b_d;

  logic is_t1, is_t2, is_t3;
  logic reg_ref_t3;
  logic late_clr;
`ifdef TIMING_CTRL_HLT_EN
  logic hlt_t3;
`endif

  // NOTE: every variable driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    is_t1      = s_q && (sc_q == SC_ONE);
    is_t2      = s_q && (sc_q == SC_T2);
    is_t3      = s_q && (sc_q == SC_T3);
    // Register-reference / I/O instructions finish at T3.
    reg_ref_t3 = is_t3 && d_q[7];
    // External end-of-instruction only honoured once fetch/decode is done.
    late_clr   = s_q && SC_CLR && (sc_q >= SC_T3);

    s_d  = s_q;
    sc_d = sc_q;
    ir_d = ir_q;
    d_d  = d_q;
    i_d  = i_q;
    b_d  = b_q;

    // START only matters while halted; when running it is ignored.
    if (!s_q && START) s_d = 1'b1;
`ifdef TIMING_CTRL_HLT_EN
    hlt_t3 = reg_ref_t3 && !i_q && b_q[0];
    if (hlt_t3) s_d = 1'b0;
`endif

    // HLT is a subset of reg_ref_t3, so it clears SC through the same path.
    if (!s_q)                        sc_d = '0;
    else if (reg_ref_t3 || late_clr) sc_d = '0;
    else                             sc_d = sc_q + SC_ONE;  // wraps 15 -> 0

    if (is_t1) ir_d = bus_in;

    if (is_t2) begin
      i_d = ir_q[WORD-1];
      d_d = 8'd1 << ir_q[WORD-2 -: 3];
      b_d = ir_q[BW-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sc_q <= '0;
      s_q  <= 1'b0;
      ir_q <= '0;
      d_q  <= '0;
      i_q  <= 1'b0;
      b_q  <= '0;
    end else begin
      sc_q <= sc_d;
      s_q  <= s_d;
      ir_q <= ir_d;
      d_q  <= d_d;
      i_q  <= i_d;
      b_q  <= b_d;
    end
  end

  // Single decoder stage from registered SC and S.
  assign T      = s_q ? (TW'(1) << sc_q) : '0;
  assign D      = d_q;
  assign I      = i_q;
  assign B      = b_q;
  assign IR_out = ir_q;
  assign S      = s_q;

endmodule

// File: tb/tb_timing_ctrl_team1.sv
// -----------------------------------------------------------------------------
// tb_timing_ctrl_team1
//
// Directed bench for timing_ctrl_team1: a vector table walks a register-
// reference and two memory-reference instructions, then hand-written sequences
// cover HLT, SC wrap and asynchronous reset mid-instruction.
// -----------------------------------------------------------------------------
module tb_timing_ctrl_team1;

  logic        clk;
  logic        RST_N;
  logic        START;
  logic [15:0] bus_in;
  logic        SC_CLR;
  logic [15:0] T;
  logic [7:0]  D;
  logic        I;
  logic [11:0] B;
  logic [15:0] IR_out;
  logic        S;

  int total;
  int bad;

  timing_ctrl_team1 #(.SC_WIDTH(4), .WORD(16)) dut (
    .clk    (clk),
    .RST_N  (RST_N),
    .START  (START),
    .bus_in (bus_in),
    .SC_CLR (SC_CLR),
    .T      (T),
    .D      (D),
    .I      (I),
    .B      (B),
    .IR_out (IR_out),
    .S      (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        sc_clr;
    logic [15:0] bus;
    logic [15:0] t;
    logic        s;
    logic [7:0]  d;
    logic        i;
    logic [11:0] b;
    logic [15:0] ir;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    START  = 1'b0;
    SC_CLR = 1'b0;
    bus_in = 16'h0000;
    repeat (2) @(posedge clk);
    #3;
    RST_N = 1'b1;
  endtask

  // Start from reset, fetch word w, and stop with the DUT in T3.
  task automatic start_and_fetch(input logic [15:0] w);
    do_reset();
    START = 1'b1;
    tick();                 // T0
    START = 1'b0;
    tick();                 // T1
    bus_in = w;
    tick();                 // T2
    bus_in = 16'h0000;
    tick();                 // T3
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // start, sc_clr, bus_in, exp T, exp S, exp D, exp I, exp B, exp IR
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1, 8'h00, 1'b0, 12'h000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 8'h00, 1'b0, 12'h000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h7800, 16'h0004, 1'b1, 8'h00, 1'b0, 12'h000, 16'h7800};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 8'h80, 1'b0, 12'h800, 16'h7800};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, 8'h80, 1'b0, 12'h800, 16'h7800};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 8'h80, 1'b0, 12'h800, 16'h7800};
    vecs[6]  = '{1'b0, 1'b0, 16'h9123, 16'h0004, 1'b1, 8'h80, 1'b0, 12'h800, 16'h9123};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 8'h02, 1'b1, 12'h123, 16'h9123};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 1'b1, 8'h02, 1'b1, 12'h123, 16'h9123};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 8'h02, 1'b1, 12'h123, 16'h9123};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, 8'h02, 1'b1, 12'h123, 16'h9123};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1, 8'h02, 1'b1, 12'h123, 16'h9123};
    vecs[12] = '{1'b0, 1'b1, 16'h2456, 16'h0004, 1'b1, 8'h02, 1'b1, 12'h123, 16'h2456};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 8'h04, 1'b0, 12'h456, 16'h2456};

    // ---------------- reset state and halted hold ----------------
    do_reset();
    check("reset_T",  32'(T),      32'h0);
    check("reset_S",  32'(S),      32'h0);
    check("reset_D",  32'(D),      32'h0);
    check("reset_I",  32'(I),      32'h0);
    check("reset_B",  32'(B),      32'h0);
    check("reset_IR", 32'(IR_out), 32'h0);
    tick();
    check("halted_T", 32'(T), 32'h0);

    // ---------------- vector table ----------------
    for (int k = 0; k < 14; k++) begin
      START  = vecs[k].start;
      SC_CLR = vecs[k].sc_clr;
      bus_in = vecs[k].bus;
      tick();
      check($sformatf("vec%0d_T",  k), 32'(T),      32'(vecs[k].t));
      check($sformatf("vec%0d_S",  k), 32'(S),      32'(vecs[k].s));
      check($sformatf("vec%0d_D",  k), 32'(D),      32'(vecs[k].d));
      check($sformatf("vec%0d_I",  k), 32'(I),      32'(vecs[k].i));
      check($sformatf("vec%0d_B",  k), 32'(B),      32'(vecs[k].b));
      check($sformatf("vec%0d_IR", k), 32'(IR_out), 32'(vecs[k].ir));
    end
    START  = 1'b0;
    SC_CLR = 1'b0;
    bus_in = 16'h0000;

    // ---------------- HLT ----------------
    start_and_fetch(16'h7001);
    check("hlt_T3",  32'(T), 32'h0008);
    check("hlt_D",   32'(D), 32'h80);
    check("hlt_B",   32'(B), 32'h001);
    START = 1'b1;           // held across the HLT edge
    tick();
`ifdef TIMING_CTRL_HLT_EN
    check("hlt_S_fall", 32'(S), 32'h0);
    check("hlt_T_zero", 32'(T), 32'h0);
    START = 1'b0;
    tick();
    check("halted_S",  32'(S),      32'h0);
    check("halted_T",  32'(T),      32'h0);
    check("halted_IR", 32'(IR_out), 32'h7001);
    check("halted_D",  32'(D),      32'h80);
    tick();
    check("halted_T2", 32'(T), 32'h0);
    START = 1'b1;
    tick();
    check("restart_T0", 32'(T), 32'h0001);
    START = 1'b0;
`else
    check("nop_S",  32'(S), 32'h1);
    check("nop_T0", 32'(T), 32'h0001);
    START = 1'b0;
    tick();
    check("nop_T1", 32'(T), 32'h0002);
    check("nop_S2", 32'(S), 32'h1);
`endif

    // ---------------- wrap: memory-ref with no SC_CLR ----------------
    start_and_fetch(16'h1123);
    check("wrap_D", 32'(D), 32'h02);
    check("wrap_B", 32'(B), 32'h123);
    for (int k = 4; k < 16; k++) begin
      tick();
      check($sformatf("wrap_T%0d", k), 32'(T), 32'(1) << k);
    end
    tick();
    check("wrap_T0", 32'(T), 32'h0001);
    check("wrap_S",  32'(S), 32'h1);

    // ---------------- asynchronous reset during T4 ----------------
    repeat (4) tick();
    check("mid_T4", 32'(T), 32'h0010);
    #2;
    RST_N = 1'b0;
    #1;                     // still well before the next rising edge
    check("async_T",  32'(T),      32'h0);
    check("async_S",  32'(S),      32'h0);
    check("async_IR", 32'(IR_out), 32'h0);
    check("async_D",  32'(D),      32'h0);
    check("async_B",  32'(B),      32'h0);
    #2;
    RST_N = 1'b1;
    START = 1'b1;
    tick();
    check("post_reset_T0", 32'(T), 32'h0001);
    START = 1'b0;
    tick();
    check("post_reset_T1", 32'(T), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
